// File: rtl/gtfraw_statsreg_tick_ctrl_pkg.sv
// Shared types and helpers for the pm_tick stats-bank sequencer.
package gtfraw_stats_pkg;

    localparam int MIN_SETTLE = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TICK    = 3'd1,
        SETTLE  = 3'd2,
        RELEASE = 3'd3,
        GUARD   = 3'd4,
        READ    = 3'd5
    } seq_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gtfraw_statsreg_tick_ctrl_if.sv
// Snapshot readout stream: one stats word per beat on valid/ready.
interface gtfraw_statsreg_tick_ctrl_if #(
    parameter int OUTWIDTH = 32,
    parameter int IDXW     = 6
);
    logic                rd_valid;
    logic                rd_ready;
    logic [OUTWIDTH-1:0] rd_data;
    logic [IDXW-1:0]     rd_idx;
    logic                rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_idx,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_idx,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/gtfraw_statsreg_tick_ctrl_timer.sv
// Periodic tick timer: raises auto_req once every `interval` cycles while enabled.
module gtfraw_tick_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        auto_en,
    input  logic [31:0] interval,
    output logic        auto_req
);
    logic [31:0] timer;
    logic        run;
    logic        hit;

    assign run = auto_en && (interval != 32'd0);
    // >= keeps the period bounded if interval shrinks below the current count
    assign hit = run && (timer >= interval - 32'd1);
    assign auto_req = hit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer <= 32'd0;
        end else if (!run || hit) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
endmodule

// File: rtl/gtfraw_statsreg_tick_ctrl.sv
// pm_tick sequencer for a stats bank: tick, settle, one-cycle hold release, then
// stream every snapshot word out over the readout port.
//
// state   | meaning
// IDLE    | waiting for a request or a pending tick; hold_output high
// TICK    | pm_tick pulse, one cycle
// SETTLE  | stats pipeline latching, SETTLE_CYCLES-1 cycles
// RELEASE | hold_output low for exactly one cycle
// GUARD   | hold_output high again; snapshot lands in statsout
// READ    | stream words 0..NUM_STATS-1, hold_output high
module gtfraw_statsreg_tick_ctrl
    import gtfraw_stats_pkg::*;
#(
    parameter int NUM_STATS     = 8,
    parameter int OUTWIDTH      = 32,
    parameter int SETTLE_CYCLES = 3,
    parameter int IDXW          = 6
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          auto_en,
    input  logic [31:0]                   interval,
    input  logic                          tick_req,
    input  logic [NUM_STATS*OUTWIDTH-1:0] stats_in,
    output logic                          pm_tick,
    output logic                          hold_output,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          overrun_clr,
    gtfraw_statsreg_tick_ctrl_if.master   rd
);
    localparam int SETTLE_EFF = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;
    localparam int SW         = clog2(SETTLE_EFF) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_STATS - 1);

    seq_state_t          state;
    logic [SW-1:0]       settle_cnt;
    logic                pending;
    logic                auto_req;
    logic                req;
    logic                overrun_set;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic [IDXW-1:0]     rd_idx_q;
    logic [OUTWIDTH-1:0] rd_data_q;
    logic [IDXW-1:0]     sel;
    logic [OUTWIDTH-1:0] next_word;

    gtfraw_tick_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .auto_en  (auto_en),
        .interval (interval),
        .auto_req (auto_req)
    );

    assign req         = tick_req | auto_req;
    assign overrun_set = (state != IDLE) && req && pending;

    // Word 0 on entry to READ, otherwise the word after the one being accepted
    always_comb begin
        sel       = (state == GUARD) ? '0 : rd_idx_q + IDXW'(1);
        next_word = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            if (sel == IDXW'(i)) begin
                next_word = stats_in[i*OUTWIDTH +: OUTWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            pm_tick     <= 1'b0;
            hold_output <= 1'b1;
            busy        <= 1'b0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            // In IDLE the pending slot is consumed; a request in that same cycle refills it
            if (state == IDLE) begin
                pending <= pending & req;
            end else if (req) begin
                pending <= 1'b1;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req || pending) begin
                        state   <= TICK;
                        pm_tick <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                TICK: begin
                    pm_tick    <= 1'b0;
                    settle_cnt <= SW'(SETTLE_EFF - 2);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        hold_output <= 1'b0;
                        state       <= RELEASE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                RELEASE: begin
                    hold_output <= 1'b1;
                    state       <= GUARD;
                end
                GUARD: begin
                    rd_valid_q <= 1'b1;
                    rd_idx_q   <= sel;
                    rd_data_q  <= next_word;
                    rd_last_q  <= (sel == LAST_IDX);
                    state      <= READ;
                end
                READ: begin
                    if (rd.rd_ready) begin
                        if (rd_last_q) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            rd_idx_q   <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            rd_idx_q  <= sel;
                            rd_data_q <= next_word;
                            rd_last_q <= (sel == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_idx   = rd_idx_q;
    assign rd.rd_last  = rd_last_q;

endmodule

// File: tb/tb_gtfraw_statsreg_tick_ctrl.sv
// Directed bench for the pm_tick sequencer: timing model plus hand-pinned checks.
module tb_gtfraw_statsreg_tick_ctrl;
    localparam int NUM_STATS = 8;
    localparam int OUTWIDTH  = 32;
    localparam int SETTLE    = 3;
    localparam int IDXW      = 6;

    logic                          clk = 1'b0;
    logic                          resetn = 1'b0;
    logic                          auto_en = 1'b0;
    logic [31:0]                   interval = 32'd0;
    logic                          tick_req = 1'b0;
    logic                          overrun_clr = 1'b0;
    logic [NUM_STATS*OUTWIDTH-1:0] stats_in;
    logic                          pm_tick;
    logic                          hold_output;
    logic                          busy;
    logic                          overrun;
    logic [31:0]                   words [NUM_STATS];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    gtfraw_statsreg_tick_ctrl_if #(.OUTWIDTH(OUTWIDTH), .IDXW(IDXW)) rd_if ();

    gtfraw_statsreg_tick_ctrl #(
        .NUM_STATS     (NUM_STATS),
        .OUTWIDTH      (OUTWIDTH),
        .SETTLE_CYCLES (SETTLE),
        .IDXW          (IDXW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .auto_en     (auto_en),
        .interval    (interval),
        .tick_req    (tick_req),
        .stats_in    (stats_in),
        .pm_tick     (pm_tick),
        .hold_output (hold_output),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .rd          (rd_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a sequence is described by its tick cycle m_t0 and the count of accepted beats m_k.
    bit m_seq = 1'b0, m_pend = 1'b0, m_ovr = 1'b0, m_run_prev = 1'b0;
    int m_t0 = 0, m_k = 0, m_start = 0;
    bit p_run, p_auto, p_req, p_set;

    function automatic bit exp_valid(input int c);
        return m_seq && ((c - m_t0) >= SETTLE + 2);
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_seq = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_k = 0; m_run_prev = 1'b0;
        end else begin
            p_run = auto_en && (interval != 32'd0);
            if (p_run && !m_run_prev) m_start = cyc;
            p_auto = 1'b0;
            if (p_run) p_auto = ((cyc - m_start) % int'(interval)) == (int'(interval) - 1);
            m_run_prev = p_run;
            p_req = tick_req || p_auto;
            p_set = 1'b0;
            if (!m_seq) begin
                if (p_req || m_pend) begin
                    m_seq = 1'b1;
                    m_t0  = cyc + 1;
                    m_k   = 0;
                end
                m_pend = m_pend && p_req;
            end else begin
                if (p_req) begin
                    if (m_pend) p_set = 1'b1;
                    else m_pend = 1'b1;
                end
                if (exp_valid(cyc) && rd_if.rd_ready) begin
                    if (m_k == NUM_STATS - 1) m_seq = 1'b0;
                    else m_k++;
                end
            end
            if (p_set) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
        cyc++;
    end

    int  c_off;
    bit  c_ev;
    always @(negedge clk) begin
        if (check_en) begin
            c_off = cyc - m_t0;
            c_ev  = exp_valid(cyc);
            chk("pm_tick", pm_tick, m_seq && c_off == 0);
            chk("hold_output", hold_output, !(m_seq && c_off == SETTLE));
            chk("busy", busy, m_seq);
            chk("overrun", overrun, m_ovr);
            chk("rd_valid", rd_if.rd_valid, c_ev);
            if (c_ev) begin
                chk("rd_idx", rd_if.rd_idx, m_k);
                chk("rd_data", rd_if.rd_data, words[m_k]);
                chk("rd_last", rd_if.rd_last, m_k == NUM_STATS - 1);
            end
        end
    end

    task automatic wait_rd_idx(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_idx == IDXW'(idx)) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pm_tick"}, pm_tick, 0);
        chk({tag, "_hold"}, hold_output, 1);
        chk({tag, "_rd_valid"}, rd_if.rd_valid, 0);
        chk({tag, "_rd_idx"}, rd_if.rd_idx, 0);
        chk({tag, "_rd_data"}, rd_if.rd_data, 0);
        chk({tag, "_rd_last"}, rd_if.rd_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
        $fatal(1);
    end

    initial begin
        int  tq, pm_at, hold_at, hold_n, vfirst, vn, last_at, busy_last, e, n, min_sp, lcyc, pcyc;
        bit  ok;
        int  q[$];

        for (int i = 0; i < NUM_STATS; i++) begin
            words[i] = 32'hA5A5_0000 + 32'(i) * 32'h1111;
        end
        words[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < NUM_STATS; i++) begin
            stats_in[i*OUTWIDTH +: OUTWIDTH] = words[i];
        end
        rd_if.rd_ready = 1'b1;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk_reset_values("reset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Single manual tick, free-flowing readout
        tq = cyc; pm_at = -1; hold_at = -1; hold_n = 0; vfirst = -1; vn = 0; last_at = -1; busy_last = -1;
        tick_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tick_req = 1'b0;
            if (pm_tick) pm_at = cyc;
            if (!hold_output) begin hold_at = cyc; hold_n++; end
            if (rd_if.rd_valid) begin
                if (vfirst < 0) vfirst = cyc;
                vn++;
                if (rd_if.rd_last) last_at = cyc;
            end
            if (busy) busy_last = cyc;
        end
        chk("t1_pm_tick_at", pm_at - tq, 1);
        chk("t1_hold_low_at", hold_at - tq, 4);
        chk("t1_hold_low_count", hold_n, 1);
        chk("t1_first_valid_at", vfirst - tq, 6);
        chk("t1_valid_count", vn, 8);
        chk("t1_last_at", last_at - tq, 13);
        chk("t1_busy_clear_at", busy_last + 1 - tq, 14);
        wait_idle(40);

        // Stall five cycles on word 3
        tick_req = 1'b1;
        @(negedge clk);
        tick_req = 1'b0;
        wait_rd_idx(3, 40, ok);
        chk("stall_reach_idx3", ok, 1);
        rd_if.rd_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_rd_data", rd_if.rd_data, 32'hDEAD_BEEF);
            chk("stall_rd_idx", rd_if.rd_idx, 3);
            chk("stall_rd_valid", rd_if.rd_valid, 1);
        end
        @(negedge clk);
        chk("stall_rd_data_end", rd_if.rd_data, 32'hDEAD_BEEF);
        rd_if.rd_ready = 1'b1;
        wait_idle(60);

        // Pending then overrun during READ; back-to-back restart; overrun_clr
        tick_req = 1'b1;
        @(negedge clk);
        tick_req = 1'b0;
        wait_rd_idx(0, 40, ok);
        chk("ovr_reach_read", ok, 1);
        chk("ovr_initially_clear", overrun, 0);
        tick_req = 1'b1;
        @(negedge clk);
        tick_req = 1'b0;
        chk("ovr_after_first_req", overrun, 0);
        @(negedge clk);
        tick_req = 1'b1;
        @(negedge clk);
        tick_req = 1'b0;
        chk("ovr_after_second_req", overrun, 1);
        lcyc = -100;
        for (int i = 0; i < 20 && lcyc < 0; i++) begin
            if (rd_if.rd_valid && rd_if.rd_last) lcyc = cyc;
            else @(negedge clk);
        end
        pcyc = -1;
        for (int i = 0; i < 10 && pcyc < 0; i++) begin
            @(negedge clk);
            if (pm_tick) pcyc = cyc;
        end
        chk("ovr_restart_after_last", pcyc - lcyc, 2);
        wait_idle(60);
        chk("ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Auto ticks at interval 100
        interval = 32'd100;
        auto_en = 1'b1;
        e = cyc;
        q.delete();
        repeat (350) begin
            @(negedge clk);
            if (pm_tick) q.push_back(cyc);
        end
        auto_en = 1'b0;
        chk("auto100_count", q.size(), 3);
        if (q.size() >= 1) chk("auto100_first", q[0] - e, 100);
        for (int i = 1; i < q.size(); i++) chk("auto100_spacing", q[i] - q[i-1], 100);
        wait_idle(60);

        // interval 0 disables auto ticks
        interval = 32'd0;
        auto_en = 1'b1;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pm_tick) n++;
        end
        auto_en = 1'b0;
        chk("interval0_ticks", n, 0);

        // interval 5: requests outpace sequences
        interval = 32'd5;
        auto_en = 1'b1;
        q.delete();
        repeat (120) begin
            @(negedge clk);
            if (pm_tick) q.push_back(cyc);
        end
        auto_en = 1'b0;
        min_sp = 1000;
        for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] < min_sp) min_sp = q[i] - q[i-1];
        chk("int5_tick_count_ge2", q.size() >= 2, 1);
        chk("int5_min_spacing_ge13", min_sp >= 13, 1);
        chk("int5_overrun", overrun, 1);
        wait_idle(100);

        // Reset mid-READ at word 4
        tick_req = 1'b1;
        @(negedge clk);
        tick_req = 1'b0;
        wait_rd_idx(4, 40, ok);
        chk("rst_reach_idx4", ok, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
        resetn = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd_if.rd_valid) n++;
        end
        chk("rst_no_valid_after", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
